// File: rtl/playseq_pkg.sv
// playseq_pkg: state encoding, default widths and timer sizing for the PlaySeq sequencer
package playseq_pkg;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 4;
  typedef enum logic [3:0] {IDLE, P_ADDR, P_WAIT, P_SHOW, P_GAP, C_ADDR, C_WAIT, C_BTN, DONE} state_t;
  function automatic int timer_w(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction
endpackage

// File: rtl/playseq_timer.sv
// playseq_timer: loadable down-counter that saturates at zero and flags it
module playseq_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign zero = cnt_q == '0;
endmodule

// File: rtl/playseq_seq_ctrl.sv
// playseq_seq_ctrl: sequence RAM owner that loads, plays back and checks button sequences
module playseq_seq_ctrl
  import playseq_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int SHOW_CYCLES    = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_play,
  input  logic              start_check,
  input  logic              abort,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              button_valid,
  input  logic [DATA_W-1:0] button_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q,
  output logic              play_valid,
  output logic [DATA_W-1:0] play_data,
  output logic              busy,
  output logic              done,
  output logic              match,
  output logic              timeout,
  output logic [ADDR_W-1:0] err_idx
);
  localparam int TW = timer_w(SHOW_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
  // WAIT spans two cycles: one for the RAM to register the address, one to latch ram_q
  localparam logic [TW-1:0] WAIT_LD = TW'(1);
  localparam logic [TW-1:0] SHOW_LD = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD  = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TW-1:0] TO_LD   = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, last_q, last_d, ram_addr_q, ram_addr_d, err_idx_q, err_idx_d;
  logic [DATA_W-1:0] exp_q, exp_d, ram_data_q, ram_data_d, play_data_q, play_data_d;
  logic ram_we_q, ram_we_d, play_valid_q, play_valid_d, busy_q, busy_d, done_q, done_d;
  logic match_q, match_d, timeout_q, timeout_d;
  logic t_load, t_zero, last_step;
  logic [TW-1:0] t_val;
  assign last_step = ptr_q == last_q;
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    last_d       = last_q;
    exp_d        = exp_q;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    play_valid_d = play_valid_q;
    play_data_d  = play_data_q;
    done_d       = 1'b0;
    match_d      = match_q;
    timeout_d    = timeout_q;
    err_idx_d    = err_idx_q;
    if (abort) begin
      state_d      = IDLE;
      play_valid_d = 1'b0;
      play_data_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_play) begin
            state_d = P_ADDR;
            ptr_d   = '0;
            last_d  = last_addr;
          end else if (start_check) begin
            state_d   = C_ADDR;
            ptr_d     = '0;
            last_d    = last_addr;
            match_d   = 1'b0;
            timeout_d = 1'b0;
            err_idx_d = '0;
          end else if (wr_req) begin
            ram_we_d   = 1'b1;
            ram_addr_d = wr_addr;
            ram_data_d = wr_data;
          end
        end
        P_ADDR, C_ADDR: begin
          ram_addr_d = ptr_q;
          state_d    = (state_q == P_ADDR) ? P_WAIT : C_WAIT;
        end
        P_WAIT: if (t_zero) begin
          state_d      = P_SHOW;
          play_valid_d = 1'b1;
          play_data_d  = ram_q;
        end
        C_WAIT: if (t_zero) begin
          state_d = C_BTN;
          exp_d   = ram_q;
        end
        P_SHOW, P_GAP: if (t_zero) begin
          play_valid_d = 1'b0;
          play_data_d  = '0;
          if (state_q == P_SHOW && GAP_CYCLES > 0) state_d = P_GAP;
          else begin
            state_d = last_step ? DONE : P_ADDR;
            done_d  = last_step;
            ptr_d   = last_step ? ptr_q : ptr_q + ADDR_W'(1);
          end
        end
        C_BTN: begin
          if (button_valid) begin
            if (button_data == exp_q) begin
              state_d = last_step ? DONE : C_ADDR;
              done_d  = last_step;
              match_d = last_step;
              ptr_d   = last_step ? ptr_q : ptr_q + ADDR_W'(1);
            end else begin
              state_d   = DONE;
              done_d    = 1'b1;
              err_idx_d = ptr_q;
            end
          end else if (TIMEOUT_CYCLES > 0 && t_zero) begin
            state_d   = DONE;
            done_d    = 1'b1;
            timeout_d = 1'b1;
            err_idx_d = ptr_q;
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    busy_d = state_d != IDLE;
    t_load = state_d != state_q;
    t_val  = (state_d == P_WAIT || state_d == C_WAIT) ? WAIT_LD :
             (state_d == P_SHOW) ? SHOW_LD :
             (state_d == P_GAP)  ? GAP_LD  :
             (state_d == C_BTN)  ? TO_LD   : '0;
  end
  playseq_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .zero     (t_zero)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      last_q       <= '0;
      exp_q        <= '0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      play_valid_q <= 1'b0;
      play_data_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      match_q      <= 1'b0;
      timeout_q    <= 1'b0;
      err_idx_q    <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      last_q       <= last_d;
      exp_q        <= exp_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      play_valid_q <= play_valid_d;
      play_data_q  <= play_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      match_q      <= match_d;
      timeout_q    <= timeout_d;
      err_idx_q    <= err_idx_d;
    end
  end
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_data   = ram_data_q;
  assign play_valid = play_valid_q;
  assign play_data  = play_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign match      = match_q;
  assign timeout    = timeout_q;
  assign err_idx    = err_idx_q;
endmodule
